icetap_capture_ctrl: RTL and testbench

- Sequencer for the icetap logic-analyzer sample datapath.
- Runs in the `clk` domain, between the `signals_in` probe bus and the sample RAM.
- Qualifies each sample with a store condition, detects the trigger, and drives RAM write address/enable as a circular pre-trigger buffer.
- Stops after a programmed post-trigger count and reports status for the JTAG readout side.

---
 rtl/icetap_pkg.sv | 25 ++
 rtl/icetap_sample_qual.sv | 65 ++++++
 rtl/icetap_capture_ctrl.sv | 165 ++++++++++++++++
 tb/tb_icetap_capture_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/icetap_pkg.sv
// Shared types and constants for the icetap capture sequencer and its JTAG register file.
// ICETAP_TIMESTAMP_EN widens the RAM word by TS_BITS of inter-store delta.
package icetap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRE_TRIG  = 2'd1,
    ST_POST_TRIG = 2'd2,
    ST_DONE      = 2'd3
  } cap_state_e;

  localparam int TS_BITS = 8;

`ifdef ICETAP_TIMESTAMP_EN
  localparam int TS_EXTRA = TS_BITS;
`else
  localparam int TS_EXTRA = 0;
`endif

  // Command opcodes as seen by the JTAG register file
  localparam logic [1:0] CMD_NOP   = 2'd0;
  localparam logic [1:0] CMD_START = 2'd1;
  localparam logic [1:0] CMD_ABORT = 2'd2;

endpackage

// File: rtl/icetap_sample_qual.sv
// Probe pipeline (s_d, prev_sample) with store and trigger qualification.
// ICETAP_TIMESTAMP_EN adds a delta counter that forces a store on saturation.
module icetap_sample_qual
  import icetap_pkg::*;
#(
  parameter int NR_SIGNALS = 8
) (
  input  logic                           clk,
  input  logic                           reset_,
  input  logic [NR_SIGNALS-1:0]          signals_in,
  input  logic                           force_store,
  input  logic                           store_always,
  input  logic [NR_SIGNALS-1:0]          store_mask,
  input  logic                           trigger_always,
  input  logic [NR_SIGNALS-1:0]          trigger_mask,
  input  logic [NR_SIGNALS-1:0]          trigger_value,
`ifdef ICETAP_TIMESTAMP_EN
  input  logic                           ts_run,
  input  logic                           ts_clear,
`endif
  output logic                           store_cond,
  output logic                           trig_cond,
  output logic [NR_SIGNALS+TS_EXTRA-1:0] sample_word
);

  logic [NR_SIGNALS-1:0] s_d;
  logic [NR_SIGNALS-1:0] prev_sample;
  logic                  change_hit;

  always_ff @(posedge clk) begin
    if (!reset_) begin
      s_d         <= '0;
      prev_sample <= '0;
    end else begin
      s_d         <= signals_in;
      prev_sample <= s_d;
    end
  end

  assign change_hit = |((s_d ^ prev_sample) & store_mask);
  assign trig_cond  = trigger_always |
                      ((s_d & trigger_mask) == (trigger_value & trigger_mask));

`ifdef ICETAP_TIMESTAMP_EN
  logic [TS_BITS-1:0] ts_q;

  // Held at zero while idle so the first stored word carries a clean delta
  always_ff @(posedge clk) begin
    if (!reset_) begin
      ts_q <= '0;
    end else if (ts_clear || !ts_run) begin
      ts_q <= '0;
    end else if (ts_q != '1) begin
      ts_q <= ts_q + 1'b1;
    end
  end

  assign store_cond  = store_always | change_hit | force_store | (ts_run & (&ts_q));
  assign sample_word = {ts_q, s_d};
`else
  assign store_cond  = store_always | change_hit | force_store;
  assign sample_word = s_d;
`endif

endmodule

// File: rtl/icetap_capture_ctrl.sv
// Capture FSM and circular write-address counter for the icetap sample RAM.
// ICETAP_TIMESTAMP_EN (see icetap_pkg) widens mem_wr_data with a time delta.
module icetap_capture_ctrl
  import icetap_pkg::*;
#(
  parameter int NR_SIGNALS = 8,
  parameter int ADDR_BITS  = 8
) (
  input  logic                           clk,
  input  logic                           reset_,
  input  logic [NR_SIGNALS-1:0]          signals_in,
  input  logic                           cmd_start,
  input  logic                           cmd_abort,
  input  logic                           store_always,
  input  logic [NR_SIGNALS-1:0]          store_mask,
  input  logic                           trigger_always,
  input  logic [NR_SIGNALS-1:0]          trigger_mask,
  input  logic [NR_SIGNALS-1:0]          trigger_value,
  input  logic [ADDR_BITS-1:0]           post_trig_cnt,
  output logic                           mem_wr_ena,
  output logic [ADDR_BITS-1:0]           mem_wr_addr,
  output logic [NR_SIGNALS+TS_EXTRA-1:0] mem_wr_data,
  output logic [1:0]                     state,
  output logic [ADDR_BITS-1:0]           trigger_addr,
  output logic                           buf_wrapped
);

  localparam logic [ADDR_BITS-1:0] ADDR_LAST = '1;

  cap_state_e                     state_q, state_d;
  logic [ADDR_BITS-1:0]           addr_q, addr_d;
  logic [ADDR_BITS-1:0]           remaining_q, remaining_d;
  logic [ADDR_BITS-1:0]           trig_addr_q, trig_addr_d;
  logic                           wrapped_q, wrapped_d;
  logic                           first_q, first_d;
  logic                           wr_ena_d;
  logic [ADDR_BITS-1:0]           wr_addr_d;
  logic [NR_SIGNALS+TS_EXTRA-1:0] wr_data_d;
  logic                           cfg_load;

  logic                           cfg_store_always, cfg_trig_always;
  logic [NR_SIGNALS-1:0]          cfg_store_mask, cfg_trig_mask, cfg_trig_value;
  logic [ADDR_BITS-1:0]           cfg_post;

  logic                           store_cond, trig_cond;
  logic [NR_SIGNALS+TS_EXTRA-1:0] sample_word;

  icetap_sample_qual #(.NR_SIGNALS(NR_SIGNALS)) u_qual (
    .clk            (clk),
    .reset_         (reset_),
    .signals_in     (signals_in),
    .force_store    (first_q),
    .store_always   (cfg_store_always),
    .store_mask     (cfg_store_mask),
    .trigger_always (cfg_trig_always),
    .trigger_mask   (cfg_trig_mask),
    .trigger_value  (cfg_trig_value),
`ifdef ICETAP_TIMESTAMP_EN
    .ts_run         ((state_q == ST_PRE_TRIG) || (state_q == ST_POST_TRIG)),
    .ts_clear       (wr_ena_d | cfg_load),
`endif
    .store_cond     (store_cond),
    .trig_cond      (trig_cond),
    .sample_word    (sample_word)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    trig_addr_d = trig_addr_q;
    wrapped_d   = wrapped_q;
    first_d     = first_q;
    wr_ena_d    = 1'b0;
    wr_addr_d   = mem_wr_addr;
    wr_data_d   = mem_wr_data;
    cfg_load    = 1'b0;

    if (cmd_abort) begin
      state_d = ST_IDLE;
      first_d = 1'b0;
    end else if (cmd_start) begin
      state_d     = ST_PRE_TRIG;
      addr_d      = '0;
      wrapped_d   = 1'b0;
      trig_addr_d = '0;
      first_d     = 1'b1;
      cfg_load    = 1'b1;
    end else begin
      case (state_q)
        ST_PRE_TRIG: begin
          if (store_cond) begin
            wr_ena_d  = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = sample_word;
            addr_d    = addr_q + 1'b1;
            first_d   = 1'b0;
            if (addr_q == ADDR_LAST) wrapped_d = 1'b1;
            if (trig_cond) begin
              trig_addr_d = addr_q;
              remaining_d = cfg_post;
              state_d     = ST_POST_TRIG;
            end
          end
        end
        ST_POST_TRIG: begin
          if (remaining_q == '0) begin
            state_d = ST_DONE;
          end else if (store_cond) begin
            wr_ena_d    = 1'b1;
            wr_addr_d   = addr_q;
            wr_data_d   = sample_word;
            addr_d      = addr_q + 1'b1;
            remaining_d = remaining_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      state_q          <= ST_IDLE;
      addr_q           <= '0;
      remaining_q      <= '0;
      trig_addr_q      <= '0;
      wrapped_q        <= 1'b0;
      first_q          <= 1'b0;
      mem_wr_ena       <= 1'b0;
      mem_wr_addr      <= '0;
      mem_wr_data      <= '0;
      cfg_store_always <= 1'b0;
      cfg_store_mask   <= '0;
      cfg_trig_always  <= 1'b0;
      cfg_trig_mask    <= '0;
      cfg_trig_value   <= '0;
      cfg_post         <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      trig_addr_q <= trig_addr_d;
      wrapped_q   <= wrapped_d;
      first_q     <= first_d;
      mem_wr_ena  <= wr_ena_d;
      mem_wr_addr <= wr_addr_d;
      mem_wr_data <= wr_data_d;
      if (cfg_load) begin
        cfg_store_always <= store_always;
        cfg_store_mask   <= store_mask;
        cfg_trig_always  <= trigger_always;
        cfg_trig_mask    <= trigger_mask;
        cfg_trig_value   <= trigger_value;
        // Never let the post-trigger run lap the buffer onto the trigger slot
        cfg_post         <= (post_trig_cnt >= ADDR_LAST) ? ADDR_LAST : post_trig_cnt;
      end
    end
  end

  assign state        = state_q;
  assign trigger_addr = trig_addr_q;
  assign buf_wrapped  = wrapped_q;

endmodule

// File: tb/tb_icetap_capture_ctrl.sv
// Directed bench for icetap_capture_ctrl (default build, NR_SIGNALS=8, ADDR_BITS=8).
// Edge Ek is the k-th rising edge after the start pulse; outputs are observed 2 time units after it.
module tb_icetap_capture_ctrl;

  logic       clk = 1'b0;
  logic       reset_;
  logic [7:0] signals_in;
  logic       cmd_start, cmd_abort;
  logic       store_always, trigger_always;
  logic [7:0] store_mask, trigger_mask, trigger_value, post_trig_cnt;
  logic       mem_wr_ena;
  logic [7:0] mem_wr_addr, mem_wr_data;
  logic [1:0] state;
  logic [7:0] trigger_addr;
  logic       buf_wrapped;

  int checks   = 0;
  int failures = 0;

  int         wr_count   = 0;
  int         watch_hits = 0;
  logic [7:0] watch_addr = 8'h00;
  int         base, hbase;

  logic       cnt_en, div2, half;
  logic [7:0] cnt_mask;

  icetap_capture_ctrl #(.NR_SIGNALS(8), .ADDR_BITS(8)) dut (
    .clk            (clk),
    .reset_         (reset_),
    .signals_in     (signals_in),
    .cmd_start      (cmd_start),
    .cmd_abort      (cmd_abort),
    .store_always   (store_always),
    .store_mask     (store_mask),
    .trigger_always (trigger_always),
    .trigger_mask   (trigger_mask),
    .trigger_value  (trigger_value),
    .post_trig_cnt  (post_trig_cnt),
    .mem_wr_ena     (mem_wr_ena),
    .mem_wr_addr    (mem_wr_addr),
    .mem_wr_data    (mem_wr_data),
    .state          (state),
    .trigger_addr   (trigger_addr),
    .buf_wrapped    (buf_wrapped)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_wr_ena === 1'b1) begin
      wr_count++;
      if (mem_wr_addr == watch_addr) watch_hits++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
    if (cnt_en) begin
      if (div2) begin
        half = ~half;
        if (!half) signals_in = (signals_in + 8'd1) & cnt_mask;
      end else begin
        signals_in = (signals_in + 8'd1) & cnt_mask;
      end
    end
  endtask

  task automatic pulse_start();
    cmd_start = 1'b1;
    cyc();
    cmd_start = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_ = 1'b0; signals_in = 8'h00; cmd_start = 1'b0; cmd_abort = 1'b0;
    store_always = 1'b0; store_mask = 8'h00; trigger_always = 1'b0;
    trigger_mask = 8'h00; trigger_value = 8'h00; post_trig_cnt = 8'h00;
    cnt_en = 1'b0; div2 = 1'b0; half = 1'b0; cnt_mask = 8'hFF;

    repeat (3) cyc();
    check("rst_state",   32'(state),        32'd0);
    check("rst_ena",     32'(mem_wr_ena),   32'd0);
    check("rst_addr",    32'(mem_wr_addr),  32'd0);
    check("rst_data",    32'(mem_wr_data),  32'd0);
    check("rst_trig",    32'(trigger_addr), 32'd0);
    check("rst_wrapped", 32'(buf_wrapped),  32'd0);
    reset_ = 1'b1;
    cyc();

    // Counter input, trigger on 0x48, 4 post writes: writes 0..0x4C, 77 in total
    store_always = 1'b1; trigger_mask = 8'hFF; trigger_value = 8'h48; post_trig_cnt = 8'd4;
    signals_in = 8'h00; cnt_en = 1'b1;
    base = wr_count;
    pulse_start();
    trigger_value = 8'h10;
    check("t1_armed", 32'(state), 32'd1);
    for (int i = 0; i < 200 && state != 2'd3; i++) cyc();
    check("t1_done",      32'(state),          32'd3);
    check("t1_trig_addr", 32'(trigger_addr),   32'h48);
    check("t1_writes",    32'(wr_count - base), 32'd77);
    check("t1_last_addr", 32'(mem_wr_addr),    32'h4C);
    check("t1_last_data", 32'(mem_wr_data),    32'h4C);
    check("t1_wrapped",   32'(buf_wrapped),    32'd0);
    repeat (5) cyc();
    check("t1_hold_writes", 32'(wr_count - base), 32'd77);
    check("t1_hold_state",  32'(state),          32'd3);

    // Change-qualified on bit0, input steps every 2 clk; trigger on first store
    store_always = 1'b0; store_mask = 8'h01; trigger_always = 1'b1; post_trig_cnt = 8'd6;
    signals_in = 8'h00; div2 = 1'b1; half = 1'b0;
    pulse_start();
    cyc();
    check("t2_state",   32'(state),        32'd2);
    check("t2_ena0",    32'(mem_wr_ena),   32'd1);
    check("t2_addr0",   32'(mem_wr_addr),  32'd0);
    check("t2_data0",   32'(mem_wr_data),  32'd0);
    check("t2_trig",    32'(trigger_addr), 32'd0);
    cyc();
    check("t2_gap1",    32'(mem_wr_ena),   32'd0);
    cyc();
    check("t2_ena1",    32'(mem_wr_ena),   32'd1);
    check("t2_addr1",   32'(mem_wr_addr),  32'd1);
    check("t2_data1",   32'(mem_wr_data),  32'd1);
    cyc();
    check("t2_gap2",    32'(mem_wr_ena),   32'd0);
    cyc();
    check("t2_ena2",    32'(mem_wr_ena),   32'd1);
    check("t2_data2",   32'(mem_wr_data),  32'd2);
    div2 = 1'b0;

    // No trigger possible (bit7 held low, trigger needs bit7=1): buffer wraps
    store_always = 1'b1; store_mask = 8'h00; trigger_always = 1'b0;
    trigger_mask = 8'h80; trigger_value = 8'h80; cnt_mask = 8'h7F; signals_in = 8'h00;
    pulse_start();
    repeat (255) cyc();
    check("t3_prewrap_flag", 32'(buf_wrapped), 32'd0);
    check("t3_prewrap_addr", 32'(mem_wr_addr), 32'hFE);
    cyc();
    check("t3_wrap_flag", 32'(buf_wrapped), 32'd1);
    check("t3_wrap_addr", 32'(mem_wr_addr), 32'hFF);
    repeat (45) cyc();
    check("t3_addr300", 32'(mem_wr_addr), 32'h2C);
    check("t3_data300", 32'(mem_wr_data), 32'h2C);
    check("t3_state",   32'(state),       32'd1);
    check("t3_wrapped", 32'(buf_wrapped), 32'd1);
    cmd_abort = 1'b1;
    cyc();
    cmd_abort = 1'b0;
    check("t3_abort_state",   32'(state),       32'd0);
    check("t3_abort_ena",     32'(mem_wr_ena),  32'd0);
    check("t3_abort_wrapped", 32'(buf_wrapped), 32'd1);
    cmd_start = 1'b1; cmd_abort = 1'b1;
    cyc();
    cmd_start = 1'b0; cmd_abort = 1'b0;
    check("t3_abort_wins", 32'(state), 32'd0);
    cnt_mask = 8'hFF; signals_in = 8'h00;
    pulse_start();
    check("t3_rearm_state",   32'(state),       32'd1);
    check("t3_rearm_wrapped", 32'(buf_wrapped), 32'd0);
    cyc();
    check("t3_rearm_ena",  32'(mem_wr_ena),  32'd1);
    check("t3_rearm_addr", 32'(mem_wr_addr), 32'd0);

    // Trigger at addr 5, 8 post; after 5 post writes (remaining=3) abort
    trigger_mask = 8'hFF; trigger_value = 8'h05; post_trig_cnt = 8'd8; signals_in = 8'h00;
    pulse_start();
    repeat (11) cyc();
    check("t4_post_state", 32'(state),        32'd2);
    check("t4_post_addr",  32'(mem_wr_addr),  32'd10);
    cmd_abort = 1'b1;
    cyc();
    cmd_abort = 1'b0;
    check("t4_abort_state", 32'(state),        32'd0);
    check("t4_abort_ena",   32'(mem_wr_ena),   32'd0);
    check("t4_abort_trig",  32'(trigger_addr), 32'd5);

    // Maximum post count: trigger at addr 0, then 255 writes to addrs 1..255
    trigger_always = 1'b1; post_trig_cnt = 8'hFF; signals_in = 8'h00; watch_addr = 8'h00;
    base = wr_count; hbase = watch_hits;
    pulse_start();
    cyc();
    check("t5_trig_ena",   32'(mem_wr_ena),  32'd1);
    check("t5_trig_state", 32'(state),       32'd2);
    for (int i = 0; i < 400 && state != 2'd3; i++) cyc();
    check("t5_done",       32'(state),             32'd3);
    check("t5_writes",     32'(wr_count - base),   32'd256);
    check("t5_slot0_hits", 32'(watch_hits - hbase), 32'd1);
    check("t5_last_addr",  32'(mem_wr_addr),       32'hFF);
    check("t5_trig_addr",  32'(trigger_addr),      32'd0);

    // Reset in the middle of a post-trigger run
    trigger_always = 1'b0; trigger_value = 8'h03; post_trig_cnt = 8'd100; signals_in = 8'h00;
    pulse_start();
    repeat (9) cyc();
    check("t6_state", 32'(state),        32'd2);
    check("t6_trig",  32'(trigger_addr), 32'd3);
    reset_ = 1'b0;
    cyc();
    check("t6_rst_state", 32'(state),        32'd0);
    check("t6_rst_ena",   32'(mem_wr_ena),   32'd0);
    check("t6_rst_addr",  32'(mem_wr_addr),  32'd0);
    check("t6_rst_data",  32'(mem_wr_data),  32'd0);
    check("t6_rst_trig",  32'(trigger_addr), 32'd0);
    reset_ = 1'b1;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
